// File: rtl/color_pkg.sv
// color_pkg: pixel colour type shared by raster and depth-buffer paths
package color_pkg;
  typedef logic [15:0] color16_t;
endpackage

// File: rtl/math_pkg.sv
// math_pkg: arbiter state encoding
package math_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} arb_state_t;
endpackage

// File: rtl/fb_sweep_counter.sv
// fb_sweep_counter: raster-order x/y sweep over the framebuffer, one pixel per enabled cycle
module fb_sweep_counter #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        en,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        last
);
  logic x_last;
  assign x_last = x == 16'(FB_WIDTH - 1);
  assign last   = x_last && y == 16'(FB_HEIGHT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      x <= x_last ? '0 : x + 16'd1;
      y <= x_last ? (last ? '0 : y + 16'd1) : y;
    end
endmodule

// File: rtl/depth_clear_arbiter.sv
// depth_clear_arbiter: muxes rasterizer pixels and a full-screen depth clear into the depth buffer
module depth_clear_arbiter
  import color_pkg::*;
  import math_pkg::*;
#(
  parameter int FB_WIDTH     = 160,
  parameter int FB_HEIGHT    = 120,
  parameter int DEPTH_BITS   = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_start,
  input  color16_t              clear_color,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  color16_t              r_color,
  input  logic [DEPTH_BITS-1:0] r_depth,
  input  logic [15:0]           r_x,
  input  logic [15:0]           r_y,
  output logic                  db_valid,
  output logic                  db_compare_depth,
  output color16_t              db_color,
  output logic [DEPTH_BITS-1:0] db_depth,
  output logic [15:0]           db_x,
  output logic [15:0]           db_y,
  output logic [15:0]           drop_count
);
  arb_state_t  state;
  logic [7:0]  cnt;
  logic [15:0] px, py, sx, sy;
  logic        start, last, in_range, fwd, drop;
  assign start      = state == IDLE && clear_start;
  assign r_ready    = state == IDLE && !clear_start;
  assign clear_busy = state != IDLE;
  assign in_range   = r_x < 16'(FB_WIDTH) && r_y < 16'(FB_HEIGHT);
  assign fwd        = r_ready && r_valid && in_range;
  assign drop       = r_ready && r_valid && !in_range;
  // during the sweep the coordinates come straight from the counter flops
  assign db_x = state == CLEAR ? sx : px;
  assign db_y = state == CLEAR ? sy : py;
  fb_sweep_counter #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT)) u_sweep (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .en   (state == CLEAR),
    .x    (sx),
    .y    (sy),
    .last (last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      clear_done       <= 1'b0;
      db_valid         <= 1'b0;
      db_compare_depth <= 1'b0;
      db_color         <= '0;
      db_depth         <= '0;
      px               <= '0;
      py               <= '0;
      drop_count       <= '0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          state            <= start ? CLEAR : IDLE;
          db_valid         <= start || fwd;
          db_compare_depth <= fwd;
          db_color         <= start ? clear_color : fwd ? r_color : '0;
          db_depth         <= start ? '1 : fwd ? r_depth : '0;
          px               <= fwd ? r_x : '0;
          py               <= fwd ? r_y : '0;
          if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
        CLEAR: if (last) begin
          state    <= DRAIN;
          cnt      <= '0;
          db_valid <= 1'b0;
          db_color <= '0;
          db_depth <= '0;
        end
        DRAIN: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'(DRAIN_CYCLES - 1)) begin
            state      <= IDLE;
            clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_depth_clear_arbiter.sv
// tb_depth_clear_arbiter: directed stimulus with a queue scoreboard checked by a db_* monitor
module tb_depth_clear_arbiter;
  import color_pkg::*;
  typedef struct packed {
    logic        cmp;
    logic [15:0] color;
    logic [31:0] depth;
    logic [15:0] x;
    logic [15:0] y;
  } beat_t;
  logic        clk = 0, rst_n = 0, clear_start = 0, r_valid = 0;
  color16_t    clear_color = '0, r_color = '0, db_color;
  logic [31:0] r_depth = '0, db_depth;
  logic [15:0] r_x = '0, r_y = '0, db_x, db_y, drop_count;
  logic        clear_busy, clear_done, r_ready, db_valid, db_compare_depth;
  beat_t       q[$];
  int          n_chk = 0, n_fail = 0, done_cnt = 0, d0, cyc;
  logic        done_prev = 0, acc, found;
  depth_clear_arbiter dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done), .r_valid(r_valid), .r_ready(r_ready),
    .r_color(r_color), .r_depth(r_depth), .r_x(r_x), .r_y(r_y), .db_valid(db_valid),
    .db_compare_depth(db_compare_depth), .db_color(db_color), .db_depth(db_depth),
    .db_x(db_x), .db_y(db_y), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_clear(input color16_t c, input int n);
    for (int i = 0; i < n; i++) q.push_back('{1'b0, c, '1, 16'(i % 160), 16'(i / 160)});
  endtask
  always @(negedge clk) begin
    beat_t a, e;
    a = '{db_compare_depth, db_color, db_depth, db_x, db_y};
    if (db_valid) begin
      chk("db_beat_expected", 96'(q.size() != 0), 96'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("db_beat", 96'(a), 96'(e));
      end
    end else chk("db_idle_zero", 96'(a), 96'(0));
    if (clear_done) begin
      done_cnt++;
      chk("clear_done_single", 96'(done_prev), 96'(0));
    end
    done_prev = clear_done;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick;
    chk("reset_db_valid", 96'(db_valid), 96'(0));
    rst_n = 1;
    tick;
    chk("reset_r_ready", 96'(r_ready), 96'(1));
    chk("reset_drop", 96'(drop_count), 96'(0));
    chk("reset_busy", 96'(clear_busy), 96'(0));
    chk("reset_done", 96'(clear_done), 96'(0));
    r_valid = 1; r_x = 5; r_y = 7; r_depth = 100; r_color = 16'hABC;
    q.push_back('{1'b1, 16'hABC, 32'd100, 16'd5, 16'd7});
    #1 chk("raster_r_ready", 96'(r_ready), 96'(1));
    tick;
    r_x = 160; r_y = 0;
    tick;
    r_x = 0; r_y = 120;
    tick;
    r_valid = 0;
    tick;
    chk("drop_count_2", 96'(drop_count), 96'(2));
    chk("raster_q_empty", 96'(q.size()), 96'(0));
    clear_color = 16'h00F; clear_start = 1;
    push_clear(16'h00F, 19200);
    d0 = done_cnt;
    tick;
    clear_start = 0;
    chk("clear_busy", 96'(clear_busy), 96'(1));
    repeat (3) tick;
    chk("clear_x_at_3", 96'(db_x), 96'(3));
    clear_start = 1;
    tick;
    clear_start = 0;
    cyc = 4;
    while (!clear_done && cyc < 20000) begin
      tick;
      cyc++;
    end
    chk("clear_done_cycle", 96'(cyc), 96'(19203));
    chk("done_r_ready", 96'(r_ready), 96'(1));
    chk("done_busy", 96'(clear_busy), 96'(0));
    tick;
    chk("clear_done_count", 96'(done_cnt - d0), 96'(1));
    chk("clear_q_empty", 96'(q.size()), 96'(0));
    clear_color = 16'h123; clear_start = 1;
    r_valid = 1; r_x = 9; r_y = 9; r_depth = 55; r_color = 16'h777;
    #1 chk("start_wins_r_ready", 96'(r_ready), 96'(0));
    push_clear(16'h123, 19200);
    q.push_back('{1'b1, 16'h777, 32'd55, 16'd9, 16'd9});
    d0 = done_cnt;
    tick;
    clear_start = 0;
    acc = 0;
    cyc = 0;
    while (!acc && cyc < 20010) begin
      @(negedge clk) acc = r_ready;
      tick;
      cyc++;
    end
    r_valid = 0;
    chk("held_pixel_accepted", 96'(acc), 96'(1));
    tick;
    chk("held_done_count", 96'(done_cnt - d0), 96'(1));
    chk("held_q_empty", 96'(q.size()), 96'(0));
    clear_color = 16'h0F0; clear_start = 1;
    push_clear(16'h0F0, 1640);
    tick;
    clear_start = 0;
    cyc = 0;
    found = 0;
    while (!found && cyc < 3000) begin
      found = db_valid && db_x == 40 && db_y == 10;
      if (!found) tick;
      cyc++;
    end
    chk("abort_pixel_seen", 96'(found), 96'(1));
    d0 = done_cnt;
    rst_n = 0;
    #1;
    chk("abort_db_valid", 96'(db_valid), 96'(0));
    chk("abort_busy", 96'(clear_busy), 96'(0));
    repeat (2) tick;
    rst_n = 1;
    tick;
    chk("abort_r_ready", 96'(r_ready), 96'(1));
    chk("abort_drop_reset", 96'(drop_count), 96'(0));
    repeat (5) tick;
    chk("abort_no_done", 96'(done_cnt - d0), 96'(0));
    chk("abort_q_empty", 96'(q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
